// File: rtl/regfile_arb.sv
// regfile_arb: shares the 1W/2R port set of the 32x32 register file between
// the core pipeline (requester 0) and the debug/loader port (requester 1).
// Requester 1 may take an exclusive lock for read-modify-write sequences.
// The lock hold time is bounded. Under fixed priority, requester 1's wait
// time is bounded as well.

module regfile_arb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int PRIO     = 0,
    parameter int MAXWAIT  = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          r0_req,
    input  logic          r0_wr,
    input  logic          r0_rd,
    input  logic [AW-1:0] r0_selwr,
    input  logic [AW-1:0] r0_selrd1,
    input  logic [AW-1:0] r0_selrd2,
    input  logic [DW-1:0] r0_in,

    input  logic          r1_req,
    input  logic          r1_wr,
    input  logic          r1_rd,
    input  logic [AW-1:0] r1_selwr,
    input  logic [AW-1:0] r1_selrd1,
    input  logic [AW-1:0] r1_selrd2,
    input  logic [DW-1:0] r1_in,
    input  logic          r1_lock,

    output logic          r0_gnt,
    output logic          r1_gnt,
    output logic          r0_rvalid,
    output logic          r1_rvalid,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,

    output logic          rf_wr,
    output logic          rf_rd,
    output logic [AW-1:0] rf_selwr,
    output logic [AW-1:0] rf_selrd1,
    output logic [AW-1:0] rf_selrd2,
    output logic [DW-1:0] rf_in,
    input  logic [DW-1:0] rf_out1,
    input  logic [DW-1:0] rf_out2
);

    localparam int WW = $clog2(MAXWAIT + 1) > 0 ? $clog2(MAXWAIT + 1) : 1;
    localparam int LW = $clog2(LOCK_MAX + 1) > 0 ? $clog2(LOCK_MAX + 1) : 1;

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        LOCK     = 2'd1,
        LOCK_EXP = 2'd2
    } state_t;

    state_t        state;
    logic          rr_last;
    logic [WW-1:0] waitcnt;
    logic [LW-1:0] lockcnt;
    logic          r0_rv_q;
    logic          r1_rv_q;
    logic          gnt0;
    logic          gnt1;

    // Pick at most one winner per cycle; the lock shuts requester 0 out entirely
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (state == LOCK) begin
                gnt1 = r1_req;
            end else if (r0_req && r1_req) begin
                if (PRIO == 0) begin
                    if (rr_last) gnt0 = 1'b1;
                    else         gnt1 = 1'b1;
                end else begin
                    if (waitcnt == WW'(MAXWAIT)) gnt1 = 1'b1;
                    else                         gnt0 = 1'b1;
                end
            end else begin
                gnt0 = r0_req;
                gnt1 = r1_req;
            end
        end
    end

    // Route the winner's op fields to the regfile, all zero when idle
    always_comb begin
        rf_wr     = 1'b0;
        rf_rd     = 1'b0;
        rf_selwr  = '0;
        rf_selrd1 = '0;
        rf_selrd2 = '0;
        rf_in     = '0;
        if (gnt0) begin
            rf_wr     = r0_wr;
            rf_rd     = r0_rd;
            rf_selwr  = r0_selwr;
            rf_selrd1 = r0_selrd1;
            rf_selrd2 = r0_selrd2;
            rf_in     = r0_in;
        end else if (gnt1) begin
            rf_wr     = r1_wr;
            rf_rd     = r1_rd;
            rf_selwr  = r1_selwr;
            rf_selrd1 = r1_selrd1;
            rf_selrd2 = r1_selrd2;
            rf_in     = r1_in;
        end
    end

    assign r0_gnt    = gnt0;
    assign r1_gnt    = gnt1;
    assign r0_rvalid = r0_rv_q && !rst;
    assign r1_rvalid = r1_rv_q && !rst;
    assign rdata1    = rf_out1;
    assign rdata2    = rf_out2;

    // Arbitration history, starvation counter, lock FSM and read-valid tags
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB;
            rr_last <= 1'b1;
            waitcnt <= '0;
            lockcnt <= '0;
            r0_rv_q <= 1'b0;
            r1_rv_q <= 1'b0;
        end else begin
            r0_rv_q <= gnt0 && r0_rd;
            r1_rv_q <= gnt1 && r1_rd;

            if (gnt0)      rr_last <= 1'b0;
            else if (gnt1) rr_last <= 1'b1;

            if (state != LOCK) begin
                if (gnt1)
                    waitcnt <= '0;
                else if (r1_req && waitcnt != WW'(MAXWAIT))
                    waitcnt <= waitcnt + WW'(1);
            end

            case (state)
                ARB: begin
                    if (gnt1 && r1_lock) begin
                        state   <= LOCK;
                        lockcnt <= '0;
                    end
                end
                LOCK: begin
                    if (!r1_lock && (gnt1 || !r1_req))
                        state <= ARB;
                    else if (lockcnt == LW'(LOCK_MAX - 1))
                        state <= LOCK_EXP;
                    else
                        lockcnt <= lockcnt + LW'(1);
                end
                LOCK_EXP: begin
                    if (!r1_lock) state <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arb.sv
// tb_regfile_arb: drives one round-robin and one fixed-priority arbiter from
// the same directed vectors. Each arbiter has its own behavioural regfile.
// The bench model predicts grants, regfile controls and read data cycle by
// cycle. Literal expectations pin the key scenarios.

module tb_regfile_arb;

    localparam int MAXW = 4;
    localparam int LMAX = 16;

    localparam logic [2:0] IDLE = 3'b000;
    localparam logic [2:0] WR   = 3'b110;
    localparam logic [2:0] RD   = 3'b101;
    localparam logic [2:0] WRRD = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_wr, r0_rd;
    logic [4:0]  r0_selwr, r0_selrd1, r0_selrd2;
    logic [31:0] r0_in;
    logic        r1_req, r1_wr, r1_rd, r1_lock;
    logic [4:0]  r1_selwr, r1_selrd1, r1_selrd2;
    logic [31:0] r1_in;

    logic [1:0]  dut_r0_gnt, dut_r1_gnt, dut_r0_rvalid, dut_r1_rvalid;
    logic [1:0]  dut_rf_wr, dut_rf_rd;
    logic [31:0] dut_rdata1 [2];
    logic [31:0] dut_rdata2 [2];
    logic [4:0]  dut_rf_selwr [2];
    logic [4:0]  dut_rf_selrd1 [2];
    logic [4:0]  dut_rf_selrd2 [2];
    logic [31:0] dut_rf_in [2];
    logic [31:0] env_out1 [2];
    logic [31:0] env_out2 [2];
    logic [31:0] env_mem [2][32];

    int n_vec = 0;
    int n_err = 0;

    int          m_mode [2];
    logic        m_last [2];
    int          m_wait [2];
    int          m_lock [2];
    logic        m_rv0 [2];
    logic        m_rv1 [2];
    logic [31:0] m_d1 [2];
    logic [31:0] m_d2 [2];
    logic [31:0] gold [2][32];

    always #5 clk = ~clk;

    regfile_arb #(.DW(32), .AW(5), .PRIO(0), .MAXWAIT(MAXW), .LOCK_MAX(LMAX)) u_rr (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_wr(r0_wr), .r0_rd(r0_rd), .r0_selwr(r0_selwr),
        .r0_selrd1(r0_selrd1), .r0_selrd2(r0_selrd2), .r0_in(r0_in),
        .r1_req(r1_req), .r1_wr(r1_wr), .r1_rd(r1_rd), .r1_selwr(r1_selwr),
        .r1_selrd1(r1_selrd1), .r1_selrd2(r1_selrd2), .r1_in(r1_in), .r1_lock(r1_lock),
        .r0_gnt(dut_r0_gnt[0]), .r1_gnt(dut_r1_gnt[0]),
        .r0_rvalid(dut_r0_rvalid[0]), .r1_rvalid(dut_r1_rvalid[0]),
        .rdata1(dut_rdata1[0]), .rdata2(dut_rdata2[0]),
        .rf_wr(dut_rf_wr[0]), .rf_rd(dut_rf_rd[0]), .rf_selwr(dut_rf_selwr[0]),
        .rf_selrd1(dut_rf_selrd1[0]), .rf_selrd2(dut_rf_selrd2[0]), .rf_in(dut_rf_in[0]),
        .rf_out1(env_out1[0]), .rf_out2(env_out2[0])
    );

    regfile_arb #(.DW(32), .AW(5), .PRIO(1), .MAXWAIT(MAXW), .LOCK_MAX(LMAX)) u_fp (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_wr(r0_wr), .r0_rd(r0_rd), .r0_selwr(r0_selwr),
        .r0_selrd1(r0_selrd1), .r0_selrd2(r0_selrd2), .r0_in(r0_in),
        .r1_req(r1_req), .r1_wr(r1_wr), .r1_rd(r1_rd), .r1_selwr(r1_selwr),
        .r1_selrd1(r1_selrd1), .r1_selrd2(r1_selrd2), .r1_in(r1_in), .r1_lock(r1_lock),
        .r0_gnt(dut_r0_gnt[1]), .r1_gnt(dut_r1_gnt[1]),
        .r0_rvalid(dut_r0_rvalid[1]), .r1_rvalid(dut_r1_rvalid[1]),
        .rdata1(dut_rdata1[1]), .rdata2(dut_rdata2[1]),
        .rf_wr(dut_rf_wr[1]), .rf_rd(dut_rf_rd[1]), .rf_selwr(dut_rf_selwr[1]),
        .rf_selrd1(dut_rf_selrd1[1]), .rf_selrd2(dut_rf_selrd2[1]), .rf_in(dut_rf_in[1]),
        .rf_out1(env_out1[1]), .rf_out2(env_out2[1])
    );

    // Register file environment: reset value of xi is i, registered reads, no bypass
    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) env_mem[p][i] <= 32'(i);
                env_out1[p] <= '0;
                env_out2[p] <= '0;
            end else begin
                if (dut_rf_rd[p]) begin
                    env_out1[p] <= env_mem[p][dut_rf_selrd1[p]];
                    env_out2[p] <= env_mem[p][dut_rf_selrd2[p]];
                end
                if (dut_rf_wr[p]) env_mem[p][dut_rf_selwr[p]] <= dut_rf_in[p];
            end
        end
    end

    task automatic checkOutput(input string name, input int p,
                               input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s u%0d: got %h expected %h at %0t", name, p, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst_v,
                                 input logic [2:0] op0, input logic [4:0] w0, a0, b0,
                                 input logic [31:0] d0,
                                 input logic [2:0] op1, input logic [4:0] w1, a1, b1,
                                 input logic [31:0] d1, input logic lock_v);
        @(posedge clk);
        #1;
        rst       = rst_v;
        r0_req    = op0[2]; r0_wr = op0[1]; r0_rd = op0[0];
        r0_selwr  = w0; r0_selrd1 = a0; r0_selrd2 = b0; r0_in = d0;
        r1_req    = op1[2]; r1_wr = op1[1]; r1_rd = op1[0];
        r1_selwr  = w1; r1_selrd1 = a1; r1_selrd2 = b1; r1_in = d1;
        r1_lock   = lock_v;
        @(negedge clk);
    endtask

    // Cycle model: predict and compare every output, then advance the model
    always @(negedge clk) begin : compare_proc
        logic        e0, e1, ew, er;
        logic [4:0]  sw, s1, s2;
        logic [31:0] din;
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                e0 = 1'b0; e1 = 1'b0;
            end else if (m_mode[p] == 1) begin
                e0 = 1'b0; e1 = r1_req;
            end else if (r0_req && r1_req) begin
                if (p == 0) e0 = m_last[p];
                else        e0 = (m_wait[p] < MAXW);
                e1 = !e0;
            end else begin
                e0 = r0_req; e1 = r1_req;
            end
            ew = 1'b0; er = 1'b0; sw = '0; s1 = '0; s2 = '0; din = '0;
            if (e0) begin
                ew = r0_wr; er = r0_rd; sw = r0_selwr; s1 = r0_selrd1; s2 = r0_selrd2; din = r0_in;
            end else if (e1) begin
                ew = r1_wr; er = r1_rd; sw = r1_selwr; s1 = r1_selrd1; s2 = r1_selrd2; din = r1_in;
            end

            checkOutput("r0_gnt", p, 32'(dut_r0_gnt[p]), 32'(e0));
            checkOutput("r1_gnt", p, 32'(dut_r1_gnt[p]), 32'(e1));
            checkOutput("rf_wr", p, 32'(dut_rf_wr[p]), 32'(ew));
            checkOutput("rf_rd", p, 32'(dut_rf_rd[p]), 32'(er));
            checkOutput("rf_selwr", p, 32'(dut_rf_selwr[p]), 32'(sw));
            checkOutput("rf_selrd1", p, 32'(dut_rf_selrd1[p]), 32'(s1));
            checkOutput("rf_selrd2", p, 32'(dut_rf_selrd2[p]), 32'(s2));
            checkOutput("rf_in", p, dut_rf_in[p], din);
            checkOutput("r0_rvalid", p, 32'(dut_r0_rvalid[p]), 32'(!rst && m_rv0[p]));
            checkOutput("r1_rvalid", p, 32'(dut_r1_rvalid[p]), 32'(!rst && m_rv1[p]));
            if (!rst && (m_rv0[p] || m_rv1[p])) begin
                checkOutput("rdata1", p, dut_rdata1[p], m_d1[p]);
                checkOutput("rdata2", p, dut_rdata2[p], m_d2[p]);
            end

            if (rst) begin
                m_mode[p] = 0; m_last[p] = 1'b1; m_wait[p] = 0; m_lock[p] = 0;
                m_rv0[p] = 1'b0; m_rv1[p] = 1'b0; m_d1[p] = '0; m_d2[p] = '0;
                for (int i = 0; i < 32; i++) gold[p][i] = 32'(i);
            end else begin
                m_rv0[p] = e0 && r0_rd;
                m_rv1[p] = e1 && r1_rd;
                if (er) begin
                    m_d1[p] = gold[p][s1];
                    m_d2[p] = gold[p][s2];
                end
                if (ew) gold[p][sw] = din;
                if (e0)      m_last[p] = 1'b0;
                else if (e1) m_last[p] = 1'b1;
                if (m_mode[p] != 1) begin
                    if (e1)                             m_wait[p] = 0;
                    else if (r1_req && m_wait[p] < MAXW) m_wait[p] = m_wait[p] + 1;
                end
                if (m_mode[p] == 0) begin
                    if (e1 && r1_lock) begin
                        m_mode[p] = 1; m_lock[p] = 0;
                    end
                end else if (m_mode[p] == 1) begin
                    m_lock[p] = m_lock[p] + 1;
                    if (!r1_lock)               m_mode[p] = 0;
                    else if (m_lock[p] == LMAX) m_mode[p] = 2;
                end else begin
                    if (!r1_lock) m_mode[p] = 0;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        r0_req = 0; r0_wr = 0; r0_rd = 0; r0_selwr = 0; r0_selrd1 = 0; r0_selrd2 = 0; r0_in = 0;
        r1_req = 0; r1_wr = 0; r1_rd = 0; r1_selwr = 0; r1_selrd1 = 0; r1_selrd2 = 0; r1_in = 0;
        r1_lock = 0;

        // reset with an active request: nothing may be granted
        applyStimulus(1, WR, 5, 0, 0, 32'h1, IDLE, 0, 0, 0, 0, 0);
        applyStimulus(1, WR, 5, 0, 0, 32'h1, IDLE, 0, 0, 0, 0, 0);
        for (int p = 0; p < 2; p++) begin
            checkOutput("lit_rst_gnt", p, 32'(dut_r0_gnt[p]), 32'd0);
            checkOutput("lit_rst_wr", p, 32'(dut_rf_wr[p]), 32'd0);
        end

        // r0 write x5 then read x5,x6
        applyStimulus(0, WR, 5, 0, 0, 32'hDEAD, IDLE, 0, 0, 0, 0, 0);
        for (int p = 0; p < 2; p++) begin
            checkOutput("lit_wr_gnt", p, 32'(dut_r0_gnt[p]), 32'd1);
            checkOutput("lit_wr_sel", p, 32'(dut_rf_selwr[p]), 32'd5);
        end
        applyStimulus(0, RD, 0, 5, 6, 32'h0, IDLE, 0, 0, 0, 0, 0);
        for (int p = 0; p < 2; p++) checkOutput("lit_rd_gnt", p, 32'(dut_r0_gnt[p]), 32'd1);
        applyStimulus(0, IDLE, 0, 0, 0, 0, IDLE, 0, 0, 0, 0, 0);
        for (int p = 0; p < 2; p++) begin
            checkOutput("lit_rvalid", p, 32'(dut_r0_rvalid[p]), 32'd1);
            checkOutput("lit_rdata1", p, dut_rdata1[p], 32'hDEAD);
            checkOutput("lit_rdata2", p, dut_rdata2[p], 32'd6);
        end

        // write and read x7 in the same op: the read sees the old value
        applyStimulus(0, WRRD, 7, 7, 7, 32'h1234, IDLE, 0, 0, 0, 0, 0);
        applyStimulus(0, RD, 0, 7, 2, 0, IDLE, 0, 0, 0, 0, 0);
        checkOutput("lit_nobypass", 0, dut_rdata1[0], 32'd7);
        applyStimulus(0, IDLE, 0, 0, 0, 0, IDLE, 0, 0, 0, 0, 0);
        checkOutput("lit_newval", 0, dut_rdata1[0], 32'h1234);

        // continuous contention: alternation vs fixed priority with bounded wait
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(0, RD, 0, 1, 2, 0, RD, 0, 3, 4, 0, 0);
            checkOutput("lit_rr_alt", 0, 32'(dut_r1_gnt[0]), 32'((c % 2) == 1));
            checkOutput("lit_fp_wait", 1, 32'(dut_r1_gnt[1]), 32'(c == 5 || c == 10));
        end
        applyStimulus(0, IDLE, 0, 0, 0, 0, IDLE, 0, 0, 0, 0, 0);

        // r1 locked read-modify-write of x3 while r0 waits
        applyStimulus(0, IDLE, 0, 0, 0, 0, RD, 0, 3, 0, 0, 1);
        for (int p = 0; p < 2; p++) checkOutput("lit_lock_gnt", p, 32'(dut_r1_gnt[p]), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(0, RD, 0, 1, 2, 0, IDLE, 0, 0, 0, 0, 1);
            for (int p = 0; p < 2; p++) checkOutput("lit_lock_block", p, 32'(dut_r0_gnt[p]), 32'd0);
            if (c == 1) checkOutput("lit_lock_rdata", 0, dut_rdata1[0], 32'd3);
        end
        applyStimulus(0, RD, 0, 1, 2, 0, WR, 3, 0, 0, 32'd4, 0);
        for (int p = 0; p < 2; p++) begin
            checkOutput("lit_unlock_r1", p, 32'(dut_r1_gnt[p]), 32'd1);
            checkOutput("lit_unlock_r0", p, 32'(dut_r0_gnt[p]), 32'd0);
        end
        applyStimulus(0, RD, 0, 1, 2, 0, IDLE, 0, 0, 0, 0, 0);
        for (int p = 0; p < 2; p++) checkOutput("lit_after_unlock", p, 32'(dut_r0_gnt[p]), 32'd1);
        applyStimulus(0, RD, 0, 3, 3, 0, IDLE, 0, 0, 0, 0, 0);
        applyStimulus(0, IDLE, 0, 0, 0, 0, IDLE, 0, 0, 0, 0, 0);
        checkOutput("lit_rmw_val", 1, dut_rdata1[1], 32'd4);

        // lock held past its limit: forced release, then r0 wins contention
        applyStimulus(0, IDLE, 0, 0, 0, 0, RD, 0, 10, 11, 0, 1);
        for (int c = 1; c <= 16; c++) begin
            applyStimulus(0, RD, 0, 12, 13, 0, RD, 0, 10, 11, 0, 1);
            for (int p = 0; p < 2; p++) checkOutput("lit_exp_hold", p, 32'(dut_r0_gnt[p]), 32'd0);
        end
        applyStimulus(0, RD, 0, 12, 13, 0, RD, 0, 10, 11, 0, 1);
        for (int p = 0; p < 2; p++) checkOutput("lit_exp_r0", p, 32'(dut_r0_gnt[p]), 32'd1);
        applyStimulus(0, RD, 0, 12, 13, 0, RD, 0, 10, 11, 0, 1);
        checkOutput("lit_exp_rr", 0, 32'(dut_r1_gnt[0]), 32'd1);
        checkOutput("lit_exp_fp", 1, 32'(dut_r0_gnt[1]), 32'd1);
        for (int c = 0; c < 3; c++) applyStimulus(0, RD, 0, 12, 13, 0, RD, 0, 10, 11, 0, 0);
        checkOutput("lit_fp_force", 1, 32'(dut_r1_gnt[1]), 32'd1);
        applyStimulus(0, IDLE, 0, 0, 0, 0, IDLE, 0, 0, 0, 0, 0);

        // reset the cycle after a read grant: the read data is never flagged
        applyStimulus(0, RD, 0, 5, 6, 0, IDLE, 0, 0, 0, 0, 0);
        applyStimulus(1, WR, 8, 0, 0, 32'hFF, RD, 0, 1, 1, 0, 0);
        for (int p = 0; p < 2; p++) begin
            checkOutput("lit_rstc_rv", p, 32'(dut_r0_rvalid[p]), 32'd0);
            checkOutput("lit_rstc_wr", p, 32'(dut_rf_wr[p]), 32'd0);
            checkOutput("lit_rstc_rd", p, 32'(dut_rf_rd[p]), 32'd0);
        end
        applyStimulus(0, IDLE, 0, 0, 0, 0, IDLE, 0, 0, 0, 0, 0);
        for (int p = 0; p < 2; p++) checkOutput("lit_postrst_rv", p, 32'(dut_r0_rvalid[p]), 32'd0);
        applyStimulus(0, RD, 0, 8, 5, 0, IDLE, 0, 0, 0, 0, 0);
        applyStimulus(0, IDLE, 0, 0, 0, 0, IDLE, 0, 0, 0, 0, 0);
        checkOutput("lit_postrst_d1", 0, dut_rdata1[0], 32'd8);
        checkOutput("lit_postrst_d2", 0, dut_rdata2[0], 32'd5);
        applyStimulus(0, IDLE, 0, 0, 0, 0, IDLE, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
